// File: rtl/cpu_run_ctrl_if.sv
// PDU/core-side signal bundle for the CPU run controller.
// master drives the PDU and core inputs; slave is the controller itself.
interface cpu_run_ctrl_if;
  logic        pdu_run;
  logic [31:0] pdu_breakpoint;
  logic [31:0] pc_if;
  logic        halt_req;
  logic        cpu_ce;
  logic        cpu_stop;
  logic [1:0]  stop_cause;
  logic [31:0] run_cycles;

  modport master (
    output pdu_run, pdu_breakpoint, pc_if, halt_req,
    input  cpu_ce, cpu_stop, stop_cause, run_cycles
  );

  modport slave (
    input  pdu_run, pdu_breakpoint, pc_if, halt_req,
    output cpu_ce, cpu_stop, stop_cause, run_cycles
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: turns the PDU run level and breakpoint into a core clock
// enable, halts on breakpoint / halt request / watchdog and reports the cause.
module cpu_run_ctrl #(
  parameter logic [31:0] WDT_LIMIT = 32'd0
) (
  input  logic          clk,
  input  logic          rstn,
  cpu_run_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 32;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_BP   = 2'b01;
  localparam logic [1:0] CAUSE_HALT = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               armed;
  logic [CNT_W-1:0]   run_cycles_q;
  logic [1:0]         cause_q;
  logic               stop_q;
  logic               bp_hit, wdt_hit, stop_cond;
  logic [1:0]         cause_nxt;
  logic               cpu_ce_c;

  // Stop detection; only meaningful while RUN and the PDU is not pausing
  always_comb begin
    bp_hit    = armed && (bus.pc_if == bus.pdu_breakpoint);
    wdt_hit   = (WDT_LIMIT != 32'd0) && (run_cycles_q == WDT_LIMIT);
    stop_cond = (state == RUN) && bus.pdu_run && (bus.halt_req || bp_hit || wdt_hit);
    if (bus.halt_req)  cause_nxt = CAUSE_HALT;
    else if (bp_hit)   cause_nxt = CAUSE_BP;
    else if (wdt_hit)  cause_nxt = CAUSE_WDT;
    else               cause_nxt = CAUSE_NONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.pdu_run) state_nxt = RUN;
      RUN:     if (stop_cond)   state_nxt = STOPPED;
      STOPPED: if (!bus.pdu_run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Zero-latency enable so the breakpoint instruction is never fetched
  always_comb begin
    cpu_ce_c = 1'b0;
    if (state == RUN) cpu_ce_c = bus.pdu_run && !stop_cond;
  end

  // Per-run bookkeeping: cleared on run start, held through pause and stop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cycles_q <= '0;
      armed        <= 1'b0;
      cause_q      <= CAUSE_NONE;
      stop_q       <= 1'b0;
    end else begin
      stop_q <= (state_nxt == STOPPED);
      if ((state == IDLE) && bus.pdu_run) begin
        run_cycles_q <= '0;
        armed        <= 1'b0;
        cause_q      <= CAUSE_NONE;
      end else if (cpu_ce_c) begin
        armed <= 1'b1;
        if (run_cycles_q != {CNT_W{1'b1}}) run_cycles_q <= run_cycles_q + CNT_W'(1);
      end else if (stop_cond) begin
        cause_q <= cause_nxt;
      end
    end
  end

  assign bus.cpu_ce     = cpu_ce_c;
  assign bus.cpu_stop   = stop_q;
  assign bus.stop_cause = cause_q;
  assign bus.run_cycles = run_cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed scoreboard bench for cpu_run_ctrl: one instance without watchdog,
// one with WDT_LIMIT=5.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  cpu_run_ctrl_if bus0 ();
  cpu_run_ctrl_if busw ();

  cpu_run_ctrl #(.WDT_LIMIT(32'd0)) u_dut0 (.clk(clk), .rstn(rstn), .bus(bus0.slave));
  cpu_run_ctrl #(.WDT_LIMIT(32'd5)) u_dutw (.clk(clk), .rstn(rstn), .bus(busw.slave));

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   tgt     = 0;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0: return {31'd0, bus0.cpu_ce};
      1: return {31'd0, bus0.cpu_stop};
      2: return {30'd0, bus0.stop_cause};
      3: return bus0.run_cycles;
      4: return {31'd0, busw.cpu_ce};
      5: return {31'd0, busw.cpu_stop};
      6: return {30'd0, busw.stop_cause};
      default: return busw.run_cycles;
    endcase
  endfunction

  task automatic push(string tag, int sel, logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp4(string tag, logic ce, logic stop, logic [1:0] cause, logic [31:0] cyc);
    int b;
    b = tgt * 4;
    push({tag, ".ce"},     b + 0, {31'd0, ce});
    push({tag, ".stop"},   b + 1, {31'd0, stop});
    push({tag, ".cause"},  b + 2, {30'd0, cause});
    push({tag, ".cycles"}, b + 3, cyc);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_total++;
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic drive(logic run, logic [31:0] bp, logic [31:0] pc, logic halt);
    if (tgt == 0) begin
      bus0.pdu_run = run; bus0.pdu_breakpoint = bp; bus0.pc_if = pc; bus0.halt_req = halt;
    end else begin
      busw.pdu_run = run; busw.pdu_breakpoint = bp; busw.pc_if = pc; busw.halt_req = halt;
    end
  endtask

  // One clock cycle: drive after the edge, compare at the falling edge
  task automatic step(string tag, logic run, logic [31:0] bp, logic [31:0] pc, logic halt,
                      logic ce, logic stop, logic [1:0] cause, logic [31:0] cyc);
    @(posedge clk);
    #1;
    drive(run, bp, pc, halt);
    exp4(tag, ce, stop, cause, cyc);
    @(negedge clk);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    tgt = 1; drive(1'b0, 32'd0, 32'd0, 1'b0);
    tgt = 0; drive(1'b0, 32'd0, 32'd0, 1'b0);
    #12;
    exp4("reset0", 1'b0, 1'b0, 2'b00, 32'd0);
    tgt = 1; exp4("resetw", 1'b0, 1'b0, 2'b00, 32'd0);
    tgt = 0;
    drain();
    @(negedge clk);
    rstn = 1'b1;

    // Breakpoint at 0x10 after four fetches
    step("t1.start", 1, 32'h10, 32'h0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 4; i++)
      step("t1.run", 1, 32'h10, 32'(i * 4), 0, 1, 0, 2'b00, 32'(i));
    step("t1.bp",   1, 32'h10, 32'h10, 0, 0, 0, 2'b00, 4);
    step("t1.stop", 1, 32'h10, 32'h10, 0, 0, 1, 2'b01, 4);
    step("t1.drop", 0, 32'h10, 32'h10, 0, 0, 1, 2'b01, 4);
    step("t1.idle", 0, 32'h10, 32'h10, 0, 0, 0, 2'b01, 4);

    // Breakpoint equal to start PC: loop of three instructions
    step("t2.start", 1, 32'h0, 32'h0, 0, 0, 0, 2'b01, 4);
    for (int i = 0; i < 3; i++)
      step("t2.run", 1, 32'h0, 32'(i * 4), 0, 1, 0, 2'b00, 32'(i));
    step("t2.bp",   1, 32'h0, 32'h0, 0, 0, 0, 2'b00, 3);
    step("t2.stop", 1, 32'h0, 32'h0, 0, 0, 1, 2'b01, 3);
    step("t2.drop", 0, 32'h0, 32'h0, 0, 0, 1, 2'b01, 3);
    step("t2.idle", 0, 32'h0, 32'h0, 0, 0, 0, 2'b01, 3);

    // Halt request coincident with breakpoint, then re-run with pause and reset
    step("t3.start", 1, 32'h8, 32'h0, 0, 0, 0, 2'b01, 3);
    for (int i = 0; i < 2; i++)
      step("t3.run", 1, 32'h8, 32'(i * 4), 0, 1, 0, 2'b00, 32'(i));
    step("t3.hit",   1, 32'h8, 32'h8, 1, 0, 0, 2'b00, 2);
    step("t3.stop",  1, 32'h8, 32'h8, 1, 0, 1, 2'b10, 2);
    step("t3.drop",  0, 32'h8, 32'h8, 0, 0, 1, 2'b10, 2);
    step("t3.idle",  0, 32'h8, 32'h8, 0, 0, 0, 2'b10, 2);
    step("t3.rerun", 1, 32'hFFFF_FFF0, 32'h0, 0, 0, 0, 2'b10, 2);
    for (int i = 0; i < 3; i++)
      step("t3.run2", 1, 32'hFFFF_FFF0, 32'(i * 4), 0, 1, 0, 2'b00, 32'(i));
    for (int i = 0; i < 10; i++)
      step("t5.pause", 0, 32'hFFFF_FFF0, 32'hC, 0, 0, 0, 2'b00, 3);
    step("t5.resume0", 1, 32'hFFFF_FFF0, 32'hC,  0, 1, 0, 2'b00, 3);
    step("t5.resume1", 1, 32'hFFFF_FFF0, 32'h10, 0, 1, 0, 2'b00, 4);
    step("t6.live",    1, 32'hFFFF_FFF0, 32'h14, 0, 1, 0, 2'b00, 5);
    #1;
    rstn = 1'b0;
    #1;
    exp4("t6.async", 0, 0, 2'b00, 0);
    drain();
    drive(1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2; i++)
      step("t6.idle", 0, 32'hFFFF_FFF0, 32'h0, 0, 0, 0, 2'b00, 0);
    step("t6.start", 1, 32'hFFFF_FFF0, 32'h0, 0, 0, 0, 2'b00, 0);
    step("t6.first", 1, 32'hFFFF_FFF0, 32'h0, 0, 1, 0, 2'b00, 0);
    step("t6.pause", 0, 32'hFFFF_FFF0, 32'h4, 0, 0, 0, 2'b00, 1);

    // Watchdog instance: limit 5
    tgt = 1;
    step("t4.start", 1, 32'hFFFF_FFF0, 32'h0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 5; i++)
      step("t4.run", 1, 32'hFFFF_FFF0, 32'(i * 4), 0, 1, 0, 2'b00, 32'(i));
    step("t4.wdt",  1, 32'hFFFF_FFF0, 32'h14, 0, 0, 0, 2'b00, 5);
    step("t4.stop", 1, 32'hFFFF_FFF0, 32'h14, 0, 0, 1, 2'b11, 5);
    step("t4.drop", 0, 32'hFFFF_FFF0, 32'h14, 0, 0, 1, 2'b11, 5);
    step("t4.idle", 0, 32'hFFFF_FFF0, 32'h14, 0, 0, 0, 2'b11, 5);

    // Watchdog and breakpoint in the same cycle: breakpoint wins
    step("t4b.start", 1, 32'h14, 32'h0, 0, 0, 0, 2'b11, 5);
    for (int i = 0; i < 5; i++)
      step("t4b.run", 1, 32'h14, 32'(i * 4), 0, 1, 0, 2'b00, 32'(i));
    step("t4b.hit",  1, 32'h14, 32'h14, 0, 0, 0, 2'b00, 5);
    step("t4b.stop", 1, 32'h14, 32'h14, 0, 0, 1, 2'b01, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

CPU-side run controller sitting between the PDU control bus and the CPU core clock-enable. It turns the PDU's `pdu_run` level and `pdu_breakpoint` address into a per-cycle CPU clock enable. It halts the core on a breakpoint match, a core halt request or a watchdog limit, and reports the halt back to the PDU through `cpu_stop` with a cause code. It also counts the enabled cycles of each run.

## Interface
- `WDT_LIMIT`, default 32'd0: maximum enabled cycles per run; 0 disables the watchdog.
- `clk` in 1: system clock (100 MHz), shared with the PDU.
- `rstn` in 1: reset, asynchronous, active-low.
- `pdu_run` in 1: PDU run level; high while the PDU is in its run state.
- `pdu_breakpoint` in 32: breakpoint PC, latched by the PDU before each run.
- `pc_if` in 32: core IF-stage PC of the instruction about to be fetched.
- `halt_req` in 1: core halt request (ebreak/ecall-exit reached); level.
- `cpu_ce` out 1: core clock enable; the core advances only in cycles where it is 1.
- `cpu_stop` out 1: level; high while halted, until the PDU drops `pdu_run`.
- `stop_cause` out 2: 00 none, 01 breakpoint, 10 halt_req, 11 watchdog.
- `run_cycles` out 32: count of `cpu_ce`=1 cycles since the current or last run started.

## Operation
- States: IDLE, RUN, STOPPED.
- IDLE:
  - `cpu_ce`=0, `cpu_stop`=0.
  - `pdu_run`=1 → RUN; in the same edge, `run_cycles`←0, `armed`←0, `stop_cause`←00.
- RUN:
  - `stop_cond` = `halt_req` | `bp_hit` | `wdt_hit`, evaluated only when `pdu_run`=1.
  - `bp_hit` = `armed` & (`pc_if` == `pdu_breakpoint`).
  - `wdt_hit` = (`WDT_LIMIT` != 0) & (`run_cycles` == `WDT_LIMIT`).
  - `cpu_ce` = `pdu_run` & ~`stop_cond`. This is combinational, so the instruction at the breakpoint is not fetched.
  - Each `cpu_ce`=1 cycle: `run_cycles`+1 (saturates at 32'hFFFFFFFF) and `armed`←1.
  - `armed` masks the breakpoint on the first enabled cycle. A breakpoint equal to the start PC means "run until this PC is reached again".
  - `pdu_run`=0 in RUN is a pause (user-input wait): `cpu_ce`=0, no state change, counters held, no stop evaluation.
  - `stop_cond`=1 → STOPPED; `stop_cause` latched with priority halt_req(10) > breakpoint(01) > watchdog(11).
- STOPPED:
  - `cpu_stop`=1, `cpu_ce`=0; `stop_cause` and `run_cycles` held.
  - `pdu_run`=0 → IDLE. `cpu_stop` therefore deasserts before the PDU's next run level, because the PDU always spends ≥1 cycle with `pdu_run`=0 before re-running.
  - `pdu_run`=1 in STOPPED: stay in STOPPED (the PDU has not yet seen the stop).
- `stop_cause` and `run_cycles` stay readable in IDLE until the next run start clears them.

## Timing
- Reset (async, any state): state=IDLE, `cpu_ce`=0, `cpu_stop`=0, `stop_cause`=00, `run_cycles`=0, `armed`=0. Reset mid-run drops `cpu_ce` immediately (asynchronously).
- `cpu_ce` is combinational from state, `pdu_run`, `halt_req`, `pc_if` and `run_cycles`, with zero latency.
- `cpu_stop` is registered: it is high the cycle after the stop condition is seen. The PDU samples it one cycle later and drops `pdu_run`. `cpu_stop` falls one cycle after that.
- Start latency: `pdu_run` rising while in IDLE gives `cpu_ce`=0 in that cycle (state still IDLE) and first `cpu_ce`=1 in the next cycle.
- Halt and breakpoint in the same cycle → cause 10. Watchdog and breakpoint in the same cycle → cause 01.
- `pdu_breakpoint` changing mid-run takes effect in the same cycle (no internal copy).

## Test plan
- Reset, then `pdu_run`=1, `pc_if` steps 0x00,0x04,…, breakpoint 0x10 → `cpu_ce` high for 4 cycles. `cpu_ce`=0 while `pc_if`=0x10, `cpu_stop`=1 the next cycle, `stop_cause`=01, `run_cycles`=4.
- Breakpoint equal to start PC 0x00, loop returning to 0x00 after 3 instructions → no stop on the first cycle; stop on the return with `run_cycles`=3.
- `halt_req` at the same cycle as a breakpoint match → `stop_cause`=10. Drop `pdu_run` → `cpu_stop`=0 next cycle, state IDLE. Re-run → `run_cycles` restarts at 0, cause 00.
- `WDT_LIMIT`=5, no breakpoint hit → exactly 5 `cpu_ce` cycles, then stop with `stop_cause`=11.
- Pause: `pdu_run` low for 10 cycles mid-run → `cpu_ce`=0 and `run_cycles` frozen; resume continues the count, no stop.
- Assert `rstn`=0 while `cpu_ce`=1 → `cpu_ce`, `cpu_stop` and `run_cycles` are 0 immediately; after release, IDLE until `pdu_run` rises.
